// File: rtl/isqrt_seq_pkg.sv
// -----------------------------------------------------------------------------
// isqrt_seq_pkg
//   Shared definitions for the sequential integer square root: FSM state
//   encoding, default radicand width and the root-width helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package isqrt_seq_pkg;

   localparam int RAD_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Root width is always half the radicand width; radicand width must be even.
   function automatic int root_w(input int rad_w);
      return rad_w / 2;
   endfunction

endpackage

// File: rtl/isqrt_seq_if.sv
// -----------------------------------------------------------------------------
// isqrt_seq_if
//   Control/data bundle between the calculator control FSM (master) and the
//   square-root unit (slave).
//   clr        master->slave  level clear, 1 = hold idle
//   radicand   master->slave  unsigned value to root
//   root       slave->master  floor(sqrt(radicand)), 0 until done
//   remainder  slave->master  radicand - root^2, 0 until done
//   busy       slave->master  1 while iterating
//   done       slave->master  1 while root/remainder are valid
// -----------------------------------------------------------------------------
interface isqrt_seq_if
   import isqrt_seq_pkg::*;
#(
   parameter int RAD_W = RAD_W_DEF
);
   localparam int ROOT_W = root_w(RAD_W);

   logic              clr;
   logic [RAD_W-1:0]  radicand;
   logic [ROOT_W-1:0] root;
   logic [ROOT_W:0]   remainder;
   logic              busy;
   logic              done;

   modport master (
      output clr, radicand,
      input  root, remainder, busy, done
   );

   modport slave (
      input  clr, radicand,
      output root, remainder, busy, done
   );

endinterface

// File: rtl/isqrt_step.sv
// -----------------------------------------------------------------------------
// isqrt_step
//   One digit-by-digit square-root iteration (combinational).
//   r       in   ROOT_W+2  partial remainder
//   q       in   ROOT_W    partial root
//   bits    in   2         next two radicand bits, MSB first
//   r_next  out  ROOT_W+2  updated partial remainder
//   q_next  out  ROOT_W    updated partial root (one more result bit)
// -----------------------------------------------------------------------------
module isqrt_step #(
   parameter int ROOT_W = 16
) (
   input  logic [ROOT_W+1:0] r,
   input  logic [ROOT_W-1:0] q,
   input  logic [1:0]        bits,
   output logic [ROOT_W+1:0] r_next,
   output logic [ROOT_W-1:0] q_next
);

   // Full-width shifted remainder so the compare sees every bit; the
   // difference itself always fits back into ROOT_W+2 bits.
   logic [ROOT_W+3:0] r_wide;
   logic [ROOT_W+1:0] trial;
   logic              take;

   assign r_wide = {r, bits};
   assign trial  = {q, 2'b01};
   assign take   = (r_wide >= {2'b00, trial});

   assign r_next = take ? (r_wide[ROOT_W+1:0] - trial) : r_wide[ROOT_W+1:0];
   assign q_next = {q[ROOT_W-2:0], take};

endmodule

// File: rtl/isqrt_seq.sv
// -----------------------------------------------------------------------------
// isqrt_seq
//   Sequential integer square root, one result bit per clock. Consumes the
//   absolute discriminant and produces floor(sqrt(x)) and x - root^2.
//   clk   in  system clock, all state changes on posedge
//   rst   in  asynchronous active-high reset
//   bus   isqrt_seq_if.slave: clr, radicand in; root, remainder, busy, done out
//   Timing: load edge + ROOT_W iteration edges; done is high after edge
//   ROOT_W+1 counted from (and including) the load edge.
// -----------------------------------------------------------------------------
module isqrt_seq
   import isqrt_seq_pkg::*;
#(
   parameter int RAD_W = RAD_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   isqrt_seq_if.slave bus
);

   localparam int ROOT_W = root_w(RAD_W);
   localparam int CNT_W  = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

   state_t            state, state_next;
   logic [RAD_W-1:0]  sh;        // latched radicand, consumed 2 bits per edge
   logic [ROOT_W-1:0] q;
   logic [ROOT_W+1:0] r;
   logic [CNT_W-1:0]  cnt;

   logic [ROOT_W-1:0] q_next;
   logic [ROOT_W+1:0] r_next;

   logic load, step_en, finish, clear_out;

   isqrt_step #(.ROOT_W(ROOT_W)) u_step (
      .r      (r),
      .q      (q),
      .bits   (sh[RAD_W-1 -: 2]),
      .r_next (r_next),
      .q_next (q_next)
   );

   // NOTE: every signal driven here gets a default first; otherwise a path
   // that skips an assignment infers a latch.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step_en    = 1'b0;
      finish     = 1'b0;
      clear_out  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!bus.clr) begin
               state_next = CALC;
               load       = 1'b1;
            end
         end
         CALC: begin
            // clr wins over completion of the last iteration.
            if (bus.clr) begin
               state_next = IDLE;
               clear_out  = 1'b1;
            end else begin
               step_en = 1'b1;
               if (cnt == '0) begin
                  state_next = DONE;
                  finish     = 1'b1;
               end
            end
         end
         DONE: begin
            if (bus.clr) begin
               state_next = IDLE;
               clear_out  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            clear_out  = 1'b1;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         sh            <= '0;
         q             <= '0;
         r             <= '0;
         cnt           <= '0;
         bus.root      <= '0;
         bus.remainder <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         state    <= state_next;
         // Flags derived from the next state keep busy/done registered and
         // mutually exclusive.
         bus.busy <= (state_next == CALC);
         bus.done <= (state_next == DONE);

         if (load) begin
            sh  <= bus.radicand;
            q   <= '0;
            r   <= '0;
            cnt <= CNT_W'(ROOT_W - 1);
         end

         if (step_en) begin
            sh  <= {sh[RAD_W-3:0], 2'b00};
            q   <= q_next;
            r   <= r_next;
            cnt <= cnt - 1'b1;
         end

         // Results are published only on the final iteration, never partials.
         if (finish) begin
            bus.root      <= q_next;
            bus.remainder <= r_next[ROOT_W:0];
         end

         if (clear_out) begin
            bus.root      <= '0;
            bus.remainder <= '0;
         end
      end
   end

endmodule

// File: tb/tb_isqrt_seq.sv
// -----------------------------------------------------------------------------
// tb_isqrt_seq
//   Self-checking bench for isqrt_seq (RAD_W = 32): table of directed
//   radicands with hand-computed results, multi-cycle corner sequences
//   (reset mid-run, clr abort, clr on final edge, DONE hold) and a batch of
//   random radicands checked against the square-root definition.
// -----------------------------------------------------------------------------
module tb_isqrt_seq;

   localparam int RAD_W   = 32;
   localparam int ROOT_W  = RAD_W / 2;
   localparam int LAT     = ROOT_W + 1;
   localparam int MAX_EDG = 40;

   typedef struct {
      logic [31:0] x;
      logic [15:0] root;
      logic [16:0] rem;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   int checks = 0;
   int errors = 0;

   isqrt_seq_if #(.RAD_W(RAD_W)) bus ();

   isqrt_seq #(.RAD_W(RAD_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d (0x%0h) exp %0d (0x%0h)", name, got, got, exp, exp);
      end
   endtask

   // Advance one posedge; return at the following negedge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_clear();
      bus.clr = 1'b1;
      tick();
   endtask

   // Drive a radicand with clr low; returns after the load edge.
   task automatic start_run(input logic [31:0] x);
      bus.radicand = x;
      bus.clr      = 1'b0;
      tick();
   endtask

   // edges counts from the load edge (=1) to the edge where done appears.
   // quiet counts samples with busy=1 and zero outputs before done.
   task automatic finish_run(output int edges, output int quiet);
      edges = 1;
      quiet = 0;
      while (!bus.done && edges < MAX_EDG) begin
         if (bus.busy && bus.root == '0 && bus.remainder == '0) quiet++;
         tick();
         edges++;
      end
   endtask

   task automatic full_run(input string name, input logic [31:0] x,
                           input logic [15:0] er, input logic [16:0] em);
      int edges, quiet;
      do_clear();
      start_run(x);
      finish_run(edges, quiet);
      check({name, " done edge"}, 64'(edges), 64'(LAT));
      check({name, " busy cycles"}, 64'(quiet), 64'(ROOT_W));
      check({name, " root"}, 64'(bus.root), 64'(er));
      check({name, " rem"}, 64'(bus.remainder), 64'(em));
      check({name, " busy in done"}, 64'(bus.busy), 64'd0);
   endtask

   vec_t vecs[$];

   initial begin
      int edges, quiet;
      logic done_seen;

      vecs = '{
         '{32'd0,          16'd0,     17'd0},
         '{32'd1,          16'd1,     17'd0},
         '{32'd2,          16'd1,     17'd1},
         '{32'd3,          16'd1,     17'd2},
         '{32'd4,          16'd2,     17'd0},
         '{32'd99,         16'd9,     17'd18},
         '{32'd144,        16'd12,    17'd0},
         '{32'd145,        16'd12,    17'd1},
         '{32'd1000,       16'd31,    17'd39},
         '{32'd1000000,    16'd1000,  17'd0},
         '{32'h4000_0000,  16'd32768, 17'd0},
         '{32'h8000_0000,  16'd46340, 17'd88048},
         '{32'hFFFE_0000,  16'd65534, 17'd131068},
         '{32'hFFFE_0001,  16'd65535, 17'd0},
         '{32'hFFFF_FFFF,  16'd65535, 17'd131070}
      };

      // Reset state
      rst          = 1'b1;
      bus.clr      = 1'b1;
      bus.radicand = '0;
      @(negedge clk);
      check("reset root", 64'(bus.root), 64'd0);
      check("reset rem", 64'(bus.remainder), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      rst = 1'b0;
      tick();
      check("idle with clr busy", 64'(bus.busy), 64'd0);

      // Directed table
      foreach (vecs[i]) full_run($sformatf("vec%0d", i), vecs[i].x, vecs[i].root, vecs[i].rem);

      // Async reset mid-CALC: outputs drop before the next clock edge
      do_clear();
      start_run(32'd1000);
      repeat (4) tick();
      check("pre-rst busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst done", 64'(bus.done), 64'd0);
      check("rst root", 64'(bus.root), 64'd0);
      check("rst rem", 64'(bus.remainder), 64'd0);
      bus.clr = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tick();
      check("post-rst no resume", 64'(bus.busy), 64'd0);
      full_run("after rst", 32'd1000, 16'd31, 17'd39);

      // clr on the 8th CALC edge aborts; done must never appear
      do_clear();
      start_run(32'd1000000);
      repeat (7) tick();
      check("abort pre busy", 64'(bus.busy), 64'd1);
      bus.clr   = 1'b1;
      done_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.done) done_seen = 1'b1;
      end
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort done seen", 64'(done_seen), 64'd0);
      check("abort root", 64'(bus.root), 64'd0);
      full_run("after abort", 32'd1000000, 16'd1000, 17'd0);

      // clr on the final iteration edge beats completion
      do_clear();
      start_run(32'd144);
      repeat (ROOT_W - 1) tick();
      check("last edge pre busy", 64'(bus.busy), 64'd1);
      bus.clr = 1'b1;
      tick();
      check("clr priority done", 64'(bus.done), 64'd0);
      check("clr priority busy", 64'(bus.busy), 64'd0);
      check("clr priority root", 64'(bus.root), 64'd0);

      // DONE holds despite radicand change; clr pulse then new run
      full_run("hold base", 32'd1000, 16'd31, 17'd39);
      bus.radicand = 32'd4;
      repeat (5) tick();
      check("hold root", 64'(bus.root), 64'd31);
      check("hold rem", 64'(bus.remainder), 64'd39);
      check("hold done", 64'(bus.done), 64'd1);
      bus.clr = 1'b1;
      tick();
      check("clr out root", 64'(bus.root), 64'd0);
      check("clr out rem", 64'(bus.remainder), 64'd0);
      check("clr out done", 64'(bus.done), 64'd0);
      start_run(32'd4);
      finish_run(edges, quiet);
      check("rerun edge", 64'(edges), 64'(LAT));
      check("rerun root", 64'(bus.root), 64'd2);
      check("rerun rem", 64'(bus.remainder), 64'd0);

      // Radicand change during CALC is ignored
      do_clear();
      start_run(32'd145);
      repeat (3) tick();
      bus.radicand = 32'hFFFF_FFFF;
      finish_run(edges, quiet);
      check("mid change root", 64'(bus.root), 64'd12);
      check("mid change rem", 64'(bus.remainder), 64'd1);

      // Random radicands against the definition of integer square root
      for (int n = 0; n < 1000; n++) begin
         logic [31:0]     x;
         longint unsigned rt, rm, xx;
         logic            ok;
         x = $urandom;
         do_clear();
         start_run(x);
         finish_run(edges, quiet);
         xx = 64'(x);
         rt = 64'(bus.root);
         rm = 64'(bus.remainder);
         ok = (edges == LAT) && (rt * rt <= xx) && ((rt + 1) * (rt + 1) > xx) && (rm == xx - rt * rt);
         if (!ok) $display("rand x=%0d root=%0d rem=%0d edges=%0d", x, rt, rm, edges);
         check($sformatf("rand%0d", n), 64'(ok), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
